// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - round-robin arbiter driving a shared 3-to-8 decoder (optional hold timeout: HOLD_TIMEOUT_EN)
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] next_start;
    logic [2:0] win_ptr;
    logic [2:0] win_next;

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
`endif

    // First set request bit scanning start, start+1, ... modulo 8.
    // Scanning from the far end down lets the nearest hit win without a found flag.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] cand;
        logic [2:0] pick;
        pick = start;
        for (int i = 7; i >= 0; i--) begin
            cand = start + 3'(i);
            if (r[cand]) pick = cand;
        end
        return pick;
    endfunction

    // Two candidate winners: one from the stored pointer, one from just past the owner.
    always_comb begin
        next_start = gnt_idx + 3'd1;
        win_ptr    = rr_pick(req, ptr);
        win_next   = rr_pick(req, next_start);
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
            ptr     <= 3'd0;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en && (req != 8'h00)) begin
                        state   <= GRANT;
                        gnt_vld <= 1'b1;
                        gnt_idx <= win_ptr;
                        gnt     <= 8'h01 << win_ptr;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!en) begin
                        // Disable drops the grant but keeps the pointer so re-enable resumes fairly.
                        state   <= IDLE;
                        gnt     <= 8'h00;
                        gnt_idx <= 3'd0;
                        gnt_vld <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end else if (!req[gnt_idx]) begin
                        ptr <= next_start;
                        if (req != 8'h00) begin
                            // Hand straight over to the next requester, no dead cycle.
                            gnt_idx <= win_next;
                            gnt     <= 8'h01 << win_next;
                        end else begin
                            state   <= IDLE;
                            gnt     <= 8'h00;
                            gnt_idx <= 3'd0;
                            gnt_vld <= 1'b0;
                        end
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end else begin
`ifdef HOLD_TIMEOUT_EN
                        if (hold_cnt == HOLD_LAST) begin
                            // Owner used its full slot: re-arbitrate past it; it wins again only if alone.
                            ptr      <= next_start;
                            gnt_idx  <= win_next;
                            gnt      <= 8'h01 << win_next;
                            hold_cnt <= 8'd0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 8'h00;
                    gnt_idx <= 3'd0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
